// File: rtl/key_debounce_pkg.sv
// Shared types and limits for the key debounce / LED block.
//   key_fsm_e          : per-channel debounce FSM state (2-bit)
//   MinSyncStages      : smallest legal synchroniser depth
//   MinDebounceCycles  : smallest legal debounce window
package key_debounce_pkg;

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } key_fsm_e;

  localparam int unsigned MinSyncStages     = 2;
  localparam int unsigned MinDebounceCycles = 1;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: synchroniser chain, stability counter, 4-state FSM and
// one-cycle press/release pulses.
// Ports:
//   sys_clk     : clock, rising edge
//   sys_rst     : synchronous active-high reset
//   key_in      : raw asynchronous key, 1 = pressed
//   key_state   : debounced level
//   key_press   : one-cycle pulse on accepted 0->1
//   key_release : one-cycle pulse on accepted 1->0
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  // Out-of-range parameters are clamped to the legal minimum.
  localparam int unsigned SyncDepth =
      (SYNC_STAGES < MinSyncStages) ? MinSyncStages : SYNC_STAGES;
  localparam int unsigned DebounceCycles =
      (DEBOUNCE_CYCLES < MinDebounceCycles) ? MinDebounceCycles : DEBOUNCE_CYCLES;
  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncDepth-1:0] sync_q;
  logic                 key_sync;
  key_fsm_e             state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;

  assign key_sync = sync_q[SyncDepth-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q    <= '0;
      state_q   <= StReleased;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SyncDepth-2:0], key_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The cycle that leaves a stable state already counts as the first stable
  // cycle, so the counter starts at 1 and acceptance happens when it reads
  // DEBOUNCE_CYCLES-1. This gives exactly DEBOUNCE_CYCLES cycles after sync.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StReleased: begin
        if (key_sync) begin
          if (DebounceCycles == 1) begin
            state_d = StPressed;
            press_d = 1'b1;
          end else begin
            state_d = StPressWait;
            cnt_d   = CntW'(1);
          end
        end
      end
      StPressWait: begin
        if (!key_sync) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!key_sync) begin
          if (DebounceCycles == 1) begin
            state_d   = StReleased;
            release_d = 1'b1;
          end else begin
            state_d = StReleaseWait;
            cnt_d   = CntW'(1);
          end
        end
      end
      StReleaseWait: begin
        if (key_sync) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d   = StReleased;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounced level is 1 in both states that follow an accepted press.
  assign key_state   = (state_q == StPressed) || (state_q == StReleaseWait);
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce_led.sv
// Multi-channel key debouncer with LED drive.
// Ports:
//   sys_clk     : clock, rising edge
//   sys_rst     : synchronous active-high reset
//   key_in      : raw asynchronous keys, 1 = pressed
//   key_state   : debounced key levels
//   key_press   : one-cycle pulses on accepted presses
//   key_release : one-cycle pulses on accepted releases
//   led_out     : LED drive, 1 = lit
// Build option KEY_DEBOUNCE_TOGGLE_EN: each LED toggles the cycle after a
// press (releases ignored); otherwise each LED mirrors its key_state.
module key_debounce_led
  import key_debounce_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] key_state,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] led_out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    key_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

`ifdef KEY_DEBOUNCE_TOGGLE_EN
  logic [CHANNELS-1:0] led_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_q ^ key_press;
    end
  end

  assign led_out = led_q;
`else
  assign led_out = key_state;
`endif

endmodule

// File: doc/key_debounce_led.md
KEY_DEBOUNCE_LED -- requirements
Module: key_debounce_led

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent key/LED channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per key, minimum 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a key change, minimum 1.
REQ-004 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 sys_rst  input  1  reset, synchronous, active-high.
REQ-006 key_in  input  CHANNELS  raw asynchronous keys, 1 = pressed.
REQ-007 key_state  output  CHANNELS  debounced key level.
REQ-008 key_press  output  CHANNELS  one-cycle pulse on an accepted 0->1 change.
REQ-009 key_release  output  CHANNELS  one-cycle pulse on an accepted 1->0 change.
REQ-010 led_out  output  CHANNELS  LED drive, 1 = lit.

Function
REQ-011 Each key_in bit SHALL pass through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-012 Each channel SHALL run a four-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED -> PRESS_WAIT when the synchronised key is 1; PRESSED -> RELEASE_WAIT when it is 0.
REQ-014 In a WAIT state the per-channel counter SHALL increment each cycle while the synchronised key holds the new level.
REQ-015 If the synchronised key reverts during a WAIT state, the FSM SHALL return to the prior stable state and clear the counter in that same cycle.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with the key still at the new level, the FSM SHALL enter the new stable state, clear the counter and update key_state on that edge.
REQ-017 Total latency from a clean key_in edge to key_state change SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles.
REQ-018 key_press and key_release SHALL be asserted for exactly the one cycle in which key_state changes; they are never asserted together on one channel.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; the counter never wraps.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels are all handled in the same cycle.

Reset
REQ-021 While sys_rst is 1: all FSMs go to RELEASED; counters, synchroniser flops, key_state, key_press, key_release and led_out go to 0.
REQ-022 Reset asserted mid-debounce SHALL abandon the pending change with no pulse.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 Macro KEY_DEBOUNCE_TOGGLE_EN defined: led_out[i] SHALL toggle on the cycle after each key_press[i] and ignore releases.
REQ-025 Macro KEY_DEBOUNCE_TOGGLE_EN undefined: led_out[i] SHALL equal key_state[i], with no toggle register present.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the FSM state enum (2-bit) and the minimum-value constants for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-027 Sub-module key_debounce_ch SHALL implement one channel (synchroniser, counter, FSM, pulses); the top SHALL instantiate it CHANNELS times via generate.

Verification
Bench config: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 20 ns clock.
REQ-028 Reset 2 cycles, then key_in=2'b01 held -> key_state[0] rises exactly 6 cycles after the key_in edge, with key_press[0] high for that single cycle; channel 1 stays 0.
REQ-029 key_in[0] high for 3 cycles, then 0 -> no key_state, key_press or key_release activity.
REQ-030 From the pressed state, key_in[0] goes 0 -> key_release[0] pulses once 6 cycles later; led_out[0] follows key_state[0] without the macro.
REQ-031 KEY_DEBOUNCE_TOGGLE_EN defined, two full press/release cycles on channel 1 -> led_out[1] goes 0 -> 1 -> 0, each change one cycle after the corresponding key_press[1].
REQ-032 sys_rst pulsed while the channel 0 counter is at 2 -> no pulse, and key_state and led_out stay 0; after reset a fresh press still takes 6 cycles.
REQ-033 key_in=2'b11 in a single cycle and held -> key_press[1:0]=2'b11 in the same cycle.
